// File: rtl/mult_div_if.sv
// Handshake and result bundle between the EXE stage and the multiply/divide unit.
interface mult_div_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        finish;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, finish, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, finish, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing {hi, lo} with a one-cycle finish pulse.
// state | meaning
// IDLE  | waiting for start
// MUL   | single product cycle
// DIV   | restoring-divide iterations, one quotient bit per cycle
// DONE  | result on hi/lo, finish pulse; may accept a new start
module mult_div_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic      clk,
  input  logic      rst,
  mult_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [4:0] LAST_ITER = 5'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic        finish_q;

  logic        accept;
  logic        in_signed_div;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        take;
  logic [31:0] rem_n, quo_n;
  logic        div_signed;
  logic [31:0] div_hi, div_lo;
  logic [32:0] mul_a, mul_b;
  logic signed [65:0] prod;
  logic        unused_bits;

  assign accept = bus.start && !bus.flush && (state_q == IDLE || state_q == DONE);

  assign bus.busy   = (state_q == MUL) || (state_q == DIV);
  assign bus.finish = finish_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: state_d = accept ? (bus.op[1] ? DIV : MUL) : IDLE;
        MUL:        state_d = DONE;
        DIV:        if (cnt_q == LAST_ITER) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Divider works on magnitudes; the signs come back in the fixup on the last iteration.
  always_comb begin
    in_signed_div = (bus.op == 2'b10);
    a_abs = (in_signed_div && bus.src_a[31]) ? -bus.src_a : bus.src_a;
    b_abs = (in_signed_div && bus.src_b[31]) ? -bus.src_b : bus.src_b;
  end

  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
    take   = !diff[33];
    rem_n  = take ? diff[31:0] : rem_sh[31:0];
    quo_n  = {quo_q[30:0], take};
  end

  always_comb begin
    div_signed = (op_q == 2'b10);
    if (b_q == 32'd0) begin
      div_hi = a_q;
      div_lo = 32'hFFFF_FFFF;
    end else begin
      div_lo = (div_signed && (a_q[31] ^ b_q[31])) ? -quo_n : quo_n;
      div_hi = (div_signed && a_q[31]) ? -rem_n : rem_n;
    end
  end

  always_comb begin
    mul_a = {(op_q[0] ? 1'b0 : a_q[31]), a_q};
    mul_b = {(op_q[0] ? 1'b0 : b_q[31]), b_q};
    prod  = $signed(mul_a) * $signed(mul_b);
  end

  assign unused_bits = ^{diff[32], prod[65:64]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      if (accept) begin
        op_q  <= bus.op;
        a_q   <= bus.src_a;
        b_q   <= bus.src_b;
        quo_q <= a_abs;
        rem_q <= '0;
        dvs_q <= b_abs;
        cnt_q <= '0;
      end else if (!bus.flush) begin
        case (state_q)
          MUL: begin
            hi_q     <= prod[63:32];
            lo_q     <= prod[31:0];
            finish_q <= 1'b1;
          end
          DIV: begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) begin
              hi_q     <= div_hi;
              lo_q     <= div_lo;
              finish_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
